execute_mc: RTL
===============

Name: execute_mc

Overview:
- Parametrised, multi-cycle execute stage between ID and WB.
- Single-cycle classes (integer, shift, logic) retire with 1-cycle latency, as in the current stage.
- Adds an iterative multiply/divide class and a visible status (flag) output.
- Uses valid/stall handshakes on both sides: v_i/stall_o toward ID, v_o/stall_i from WB.

Parameters:
- WORD, 32, datapath width in bits (>=8).
- W_RD, 5, destination register number width.
- W_OPC, 4, sub-opcode width.
- W_STATUS, 4, flag width, ordered {N,Z,C,V}.
- W_DOPC, 7, one-hot class vector width: {inte,shift,logic,load,store,branch,muldiv}, MSB first.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- v_i  in  1  ID presents a valid instruction.
- stall_o  out  1  stage cannot accept this cycle.
- src_i  in  WORD  second operand.
- dest_i  in  WORD  first operand.
- wb_i  in  1  instruction writes rd.
- rd_num_i  in  W_RD  destination register number.
- dopc_i  in  W_DOPC  one-hot class.
- opc_i  in  W_OPC  sub-opcode.
- stall_i  in  1  WB cannot accept.
- v_o  out  1  output valid.
- wb_o  out  1  registered wb.
- rd_num_o  out  W_RD  registered rd number.
- rd_data_o  out  WORD  registered result.
- status_o  out  W_STATUS  current flags register.

Behaviour:
- Reset (rst low, asynchronous): v_o, wb_o, rd_num_o, rd_data_o and status_o are 0; FSM is IDLE; iteration counter is 0; stall_o is 0 while in reset.
- Operand order: result = dest_i OP src_i.
- out_free = ~(v_o & stall_i). When out_free is 0, the output register holds all fields.
- stall_o = (v_o & stall_i) | (FSM != IDLE).
- accept = v_i & ~stall_o. When stall_o is high, ID holds its inputs stable.
- Single-cycle path (IDLE, accept, class inte/shift/logic):
  - Output register loads on the next edge, with v_o=1.
  - Flags update on the same edge.
- IDLE with out_free and no accept: v_o goes to 0 on the next edge (bubble).
- Classes load/store/branch: outside this block's scope. They are accepted and pass v/wb/rd_num through; rd_data is 0 and flags are unchanged.
- dopc_i zero or not one-hot: instruction is accepted; v_o=1, wb_o forced 0, rd_data 0, flags unchanged.
- muldiv opc codes: 0 MUL (low WORD bits), 1 MULHU (unsigned high WORD bits), 2 DIVU (quotient), 3 REMU (remainder). Other codes behave like opc 0.
- muldiv FSM:
  - IDLE -> BUSY on accept. Operands, opc, wb and rd_num are latched; counter is cleared.
  - BUSY: one shift-add or restoring-subtract step per cycle; counter increments. If out_free, v_o drops to 0 (a previous result drains normally).
  - At counter==WORD-1: if out_free, the result and flags load into the output register with v_o=1 and the FSM goes to IDLE. Otherwise the FSM goes to DONE.
  - DONE: hold the result. On the first out_free cycle, load the output register and go to IDLE.
- Latency from accept edge to v_o: 1 for single-cycle classes; WORD+1 edges for muldiv when stall_i stays low.
- A new instruction can be accepted in the cycle the FSM is in IDLE again, i.e. the cycle after the result loads.
- Divide by zero: quotient = all ones, remainder = dest_i, V=1.
- Flags:
  - Z = (result==0); N = result[WORD-1].
  - C: integer carry/borrow, or the last bit shifted out; 0 for logic and muldiv.
  - V: signed overflow for integer ops; 0 for shift/logic; muldiv sets V only on divide by zero, and for MUL when the high half is nonzero.
- Flags are written only when the result actually enters the output register.
- Reset asserted mid-BUSY or mid-DONE: the operation is discarded entirely; no partial result ever appears on v_o.

Decomposition:
- Shared include params.vh holds:
  - WORD, W_RD, W_OPC, W_STATUS, W_DOPC defaults;
  - dopc bit indices;
  - muldiv opc codes;
  - flag bit positions.
- Existing combinational helpers inte_mod, shift_mod and logic_mod are reused.
- One sub-module: muldiv_unit. It takes start, opc, a, b and returns busy, done, result, flags, with the counter internal.
- The FSM owning the handshake stays in execute_mc.

Test Plan:
1. ADD 0x7FFFFFFF + 0x00000001, stall_i=0 -> one edge later v_o=1, rd_data_o=0x80000000, status_o N=1 Z=0 C=0 V=1.
2. MUL 0x00010000*0x00010000 -> stall_o high for 32 cycles, v_o=1 on edge 33, rd_data_o=0, Z=1, V=1. The same operands with MULHU give 0x00000001.
3. DIVU 100/7 -> rd_data_o=14; REMU 100/7 -> rd_data_o=2. DIVU 5/0 -> rd_data_o=0xFFFFFFFF, V=1.
4. Back-to-back ADDs with stall_i held high for 3 cycles after the first -> v_o, rd_data_o and status_o frozen and stall_o=1 for those 3 cycles. On release, the second result follows one edge later with no loss or duplication.
5. DIVU completes while stall_i=1 -> FSM in DONE and stall_o=1. The result appears the cycle after stall_i falls, and exactly once.
6. rst pulsed low at counter=10 of a DIVU -> all outputs 0 immediately and stall_o=0. A subsequent DIVU 9/3 returns 3 with the normal latency.

Source files
------------

// File: rtl/execute_mc_pkg.sv
// Shared constants for the multi-cycle execute stage: default widths, class
// bit positions in the one-hot dopc vector, sub-opcodes, flag layout and FSM states.
package execute_mc_pkg;

  localparam int WORD_DEF     = 32;
  localparam int W_RD_DEF     = 5;
  localparam int W_OPC_DEF    = 4;
  localparam int W_STATUS_DEF = 4;
  localparam int W_DOPC_DEF   = 7;

  // dopc is {inte,shift,logic,load,store,branch,muldiv}, MSB first
  localparam int DOPC_INTE   = 6;
  localparam int DOPC_SHIFT  = 5;
  localparam int DOPC_LOGIC  = 4;
  localparam int DOPC_LOAD   = 3;
  localparam int DOPC_STORE  = 2;
  localparam int DOPC_BRANCH = 1;
  localparam int DOPC_MULDIV = 0;

  localparam int OPC_ADD = 0;
  localparam int OPC_SUB = 1;
  localparam int OPC_SLL = 0;
  localparam int OPC_SRL = 1;
  localparam int OPC_SRA = 2;
  localparam int OPC_AND = 0;
  localparam int OPC_OR  = 1;
  localparam int OPC_XOR = 2;

  localparam int MD_MUL   = 0;
  localparam int MD_MULHU = 1;
  localparam int MD_DIVU  = 2;
  localparam int MD_REMU  = 3;

  // status is {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/execute_mc_muldiv_unit.sv
// Iterative unsigned multiply / restoring divide, one step per cycle over WORD cycles.
// hi_q/lo_q serve as {product hi, product lo} or {remainder, quotient}.
module muldiv_unit
  import execute_mc_pkg::*;
#(
  parameter int WORD     = WORD_DEF,
  parameter int W_OPC    = W_OPC_DEF,
  parameter int W_STATUS = W_STATUS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [W_OPC-1:0]    opc_i,
  input  logic [WORD-1:0]     a_i,
  input  logic [WORD-1:0]     b_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [WORD-1:0]     result_o,
  output logic [W_STATUS-1:0] flags_o
);

  localparam int W_CNT = $clog2(WORD);

  logic             busy_q;
  logic [W_CNT-1:0] cnt_q;
  logic [W_OPC-1:0] opc_q;
  logic [WORD-1:0]  b_q, hi_q, lo_q;

  logic            is_divu, is_remu, is_mulhu, is_div;
  logic [WORD:0]   add_s, shl_s, sub_s;
  logic [WORD-1:0] hi_s, lo_s, hi_f, lo_f;

  assign is_divu  = (opc_q == W_OPC'(MD_DIVU));
  assign is_remu  = (opc_q == W_OPC'(MD_REMU));
  assign is_mulhu = (opc_q == W_OPC'(MD_MULHU));
  assign is_div   = is_divu | is_remu;

  always_comb begin
    add_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shl_s = {hi_q, lo_q[WORD-1]};
    sub_s = shl_s - {1'b0, b_q};
    if (is_div) begin
      // The partial remainder stays below the divisor, so the borrow bit alone decides
      hi_s = sub_s[WORD] ? shl_s[WORD-1:0] : sub_s[WORD-1:0];
      lo_s = {lo_q[WORD-2:0], ~sub_s[WORD]};
    end else begin
      hi_s = add_s[WORD:1];
      lo_s = {add_s[0], lo_q[WORD-1:1]};
    end
  end

  // While busy the final step is still combinational; afterwards the registers hold it
  assign hi_f = busy_q ? hi_s : hi_q;
  assign lo_f = busy_q ? lo_s : lo_q;

  always_comb begin
    result_o = lo_f;
    if (is_mulhu || is_remu) result_o = hi_f;
    flags_o         = '0;
    flags_o[FLAG_N] = result_o[WORD-1];
    flags_o[FLAG_Z] = (result_o == '0);
    flags_o[FLAG_V] = is_div ? (b_q == '0) : (!is_mulhu && (hi_f != '0));
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == W_CNT'(WORD - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      opc_q  <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      opc_q  <= opc_i;
      b_q    <= b_i;
      hi_q   <= '0;
      lo_q   <= a_i;
    end else if (busy_q) begin
      hi_q  <= hi_s;
      lo_q  <= lo_s;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_mc.sv
// Multi-cycle execute stage: single-cycle integer/shift/logic ops, pass-through of
// load/store/branch, and an iterative muldiv class, with valid/stall handshakes.
module execute_mc
  import execute_mc_pkg::*;
#(
  parameter int WORD     = WORD_DEF,
  parameter int W_RD     = W_RD_DEF,
  parameter int W_OPC    = W_OPC_DEF,
  parameter int W_STATUS = W_STATUS_DEF,
  parameter int W_DOPC   = W_DOPC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                v_i,
  output logic                stall_o,
  input  logic [WORD-1:0]     src_i,
  input  logic [WORD-1:0]     dest_i,
  input  logic                wb_i,
  input  logic [W_RD-1:0]     rd_num_i,
  input  logic [W_DOPC-1:0]   dopc_i,
  input  logic [W_OPC-1:0]    opc_i,
  input  logic                stall_i,
  output logic                v_o,
  output logic                wb_o,
  output logic [W_RD-1:0]     rd_num_o,
  output logic [WORD-1:0]     rd_data_o,
  output logic [W_STATUS-1:0] status_o
);

  localparam int W_SH = $clog2(WORD);

  state_e              state_q, state_d;
  logic                v_q, v_d, wb_q, wb_d;
  logic [W_RD-1:0]     rd_num_q, rd_num_d, md_rd_q;
  logic [WORD-1:0]     rd_data_q, rd_data_d;
  logic [W_STATUS-1:0] status_q, status_d;
  logic                md_wb_q;

  logic                out_free, accept, onehot, is_md, is_sc, md_start, load_md;
  logic                md_busy, md_done;
  logic [WORD-1:0]     md_result, sc_res;
  logic [W_STATUS-1:0] md_flags, sc_flags;
  logic                sc_c, sc_v;
  logic [WORD:0]       sum, sh_l, sh_r;
  logic [W_SH-1:0]     shamt;

  assign out_free = ~(v_q & stall_i);
  assign stall_o  = (v_q & stall_i) | (state_q != ST_IDLE) | md_busy;
  assign accept   = v_i & ~stall_o;
  assign onehot   = $onehot(dopc_i);
  assign is_md    = onehot & dopc_i[DOPC_MULDIV];
  assign is_sc    = onehot & (dopc_i[DOPC_INTE] | dopc_i[DOPC_SHIFT] | dopc_i[DOPC_LOGIC]);
  assign md_start = accept & is_md;
  assign shamt    = src_i[W_SH-1:0];

  muldiv_unit #(.WORD(WORD), .W_OPC(W_OPC), .W_STATUS(W_STATUS)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .opc_i    (opc_i),
    .a_i      (dest_i),
    .b_i      (src_i),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result),
    .flags_o  (md_flags)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sum    = '0;
    sh_l   = '0;
    sh_r   = '0;
    if (dopc_i[DOPC_INTE]) begin
      if (opc_i == W_OPC'(OPC_SUB)) begin
        sum  = {1'b0, dest_i} - {1'b0, src_i};
        sc_v = (dest_i[WORD-1] != src_i[WORD-1]) && (sum[WORD-1] != dest_i[WORD-1]);
      end else begin
        sum  = {1'b0, dest_i} + {1'b0, src_i};
        sc_v = (dest_i[WORD-1] == src_i[WORD-1]) && (sum[WORD-1] != dest_i[WORD-1]);
      end
      sc_res = sum[WORD-1:0];
      sc_c   = sum[WORD];
    end else if (dopc_i[DOPC_SHIFT]) begin
      // One guard bit beside the operand catches the last bit shifted out (0 for amount 0)
      if (opc_i == W_OPC'(OPC_SRL)) begin
        sh_r   = {dest_i, 1'b0} >> shamt;
        sc_res = sh_r[WORD:1];
        sc_c   = sh_r[0];
      end else if (opc_i == W_OPC'(OPC_SRA)) begin
        sh_r   = $unsigned($signed({dest_i, 1'b0}) >>> shamt);
        sc_res = sh_r[WORD:1];
        sc_c   = sh_r[0];
      end else begin
        sh_l   = {1'b0, dest_i} << shamt;
        sc_res = sh_l[WORD-1:0];
        sc_c   = sh_l[WORD];
      end
    end else if (dopc_i[DOPC_LOGIC]) begin
      if (opc_i == W_OPC'(OPC_OR))       sc_res = dest_i | src_i;
      else if (opc_i == W_OPC'(OPC_XOR)) sc_res = dest_i ^ src_i;
      else                               sc_res = dest_i & src_i;
    end
    sc_flags         = '0;
    sc_flags[FLAG_N] = sc_res[WORD-1];
    sc_flags[FLAG_Z] = (sc_res == '0);
    sc_flags[FLAG_C] = sc_c;
    sc_flags[FLAG_V] = sc_v;
  end

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    wb_d      = wb_q;
    rd_num_d  = rd_num_q;
    rd_data_d = rd_data_q;
    status_d  = status_q;
    load_md   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (out_free) begin
          v_d = 1'b0;
          if (accept && is_md) begin
            state_d = ST_BUSY;
          end else if (accept) begin
            v_d       = 1'b1;
            wb_d      = wb_i & onehot;
            rd_num_d  = rd_num_i;
            rd_data_d = '0;
            if (is_sc) begin
              rd_data_d = sc_res;
              status_d  = sc_flags;
            end
          end
        end
      end
      ST_BUSY: begin
        if (md_done) begin
          load_md = out_free;
          state_d = out_free ? ST_IDLE : ST_DONE;
        end else if (out_free) begin
          v_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_free) begin
          load_md = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_md) begin
      v_d       = 1'b1;
      wb_d      = md_wb_q;
      rd_num_d  = md_rd_q;
      rd_data_d = md_result;
      status_d  = md_flags;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      v_q       <= 1'b0;
      wb_q      <= 1'b0;
      rd_num_q  <= '0;
      rd_data_q <= '0;
      status_q  <= '0;
      md_wb_q   <= 1'b0;
      md_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      wb_q      <= wb_d;
      rd_num_q  <= rd_num_d;
      rd_data_q <= rd_data_d;
      status_q  <= status_d;
      if (md_start) begin
        md_wb_q <= wb_i;
        md_rd_q <= rd_num_i;
      end
    end
  end

  assign v_o       = v_q;
  assign wb_o      = wb_q;
  assign rd_num_o  = rd_num_q;
  assign rd_data_o = rd_data_q;
  assign status_o  = status_q;

endmodule
